// File: rtl/hamming_dec_s.sv
// Sequential Hamming(10,6) decoder: scans one codeword position per cycle to build the
// syndrome, then corrects a single-bit error and publishes the result with a done pulse.
module hamming_dec_s (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] cw_in,
  output logic       busy,
  output logic       done,
  output logic [5:0] d_out,
  output logic [3:0] syndrome,
  output logic       err,
  output logic       uerr,
  output logic [3:0] d_disp0,
  output logic [3:0] d_disp1,
  output logic [3:0] d_disp2,
  output logic [3:0] d_disp3
);

  typedef enum logic [1:0] {StIdle, StScan, StCorrect, StDone} state_e;

  state_e     state_q, state_d;
  logic [9:0] cw_q, cw_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] d_out_q, d_out_d;
  logic [3:0] syn_q, syn_d;
  logic       err_q, err_d;
  logic       uerr_q, uerr_d;

  logic       cur_bit;
  logic [9:0] flip;
  logic [9:0] fixed;

  // Bit of the latched codeword at the current scan position (positions are 1-based).
  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cnt_q == 4'(i + 1)) cur_bit = cw_q[i];
    end
  end

  // One-hot correction mask; stays zero for syndrome 0 and for 11..15.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 10; i++) begin
      flip[i] = (acc_q == 4'(i + 1));
    end
  end

  assign fixed = cw_q ^ flip;

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    syn_d   = syn_q;
    err_d   = err_q;
    uerr_d  = uerr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cw_d    = cw_in;
          acc_d   = '0;
          cnt_d   = 4'd1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (cur_bit) acc_d = acc_q ^ cnt_q;
        if (cnt_q == 4'd10) begin
          state_d = StCorrect;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCorrect: begin
        cw_d    = fixed;
        d_out_d = {fixed[9], fixed[8], fixed[6], fixed[5], fixed[4], fixed[2]};
        syn_d   = acc_q;
        err_d   = |flip;
        uerr_d  = (acc_q >= 4'd11);
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cw_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      d_out_q <= '0;
      syn_q   <= '0;
      err_q   <= 1'b0;
      uerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      uerr_q  <= uerr_d;
    end
  end

  assign busy     = (state_q == StScan) || (state_q == StCorrect);
  assign done     = (state_q == StDone);
  assign d_out    = d_out_q;
  assign syndrome = syn_q;
  assign err      = err_q;
  assign uerr     = uerr_q;
  assign d_disp0  = d_out_q[3:0];
  assign d_disp1  = {2'b00, d_out_q[5:4]};
  assign d_disp2  = syn_q;
  assign d_disp3  = uerr_q ? 4'h2 : (err_q ? 4'h1 : 4'h0);

endmodule

// File: tb/tb_hamming_dec_s.sv
// Self-checking bench for hamming_dec_s: a table of directed codewords plus hand-written
// sequences for busy-time start, input changes, mid-decode reset and back-to-back decodes.
module tb_hamming_dec_s;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] cw_in;
  logic       busy;
  logic       done;
  logic [5:0] d_out;
  logic [3:0] syndrome;
  logic       err;
  logic       uerr;
  logic [3:0] d_disp0;
  logic [3:0] d_disp1;
  logic [3:0] d_disp2;
  logic [3:0] d_disp3;

  int n_tests = 0;
  int n_fail  = 0;

  hamming_dec_s dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cw_in    (cw_in),
    .busy     (busy),
    .done     (done),
    .d_out    (d_out),
    .syndrome (syndrome),
    .err      (err),
    .uerr     (uerr),
    .d_disp0  (d_disp0),
    .d_disp1  (d_disp1),
    .d_disp2  (d_disp2),
    .d_disp3  (d_disp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500000");
    $fatal(1);
  end

  typedef struct {
    logic [9:0] cw;
    logic [5:0] d;
    logic [3:0] syn;
    logic       err;
    logic       uerr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [5:0] d, input logic [3:0] syn,
                              input logic e, input logic u);
    check({tag, "_dout"}, 32'(d_out), 32'(d));
    check({tag, "_syn"}, 32'(syndrome), 32'(syn));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_uerr"}, 32'(uerr), 32'(u));
    check({tag, "_disp0"}, 32'(d_disp0), 32'(d[3:0]));
    check({tag, "_disp1"}, 32'(d_disp1), 32'({2'b00, d[5:4]}));
    check({tag, "_disp2"}, 32'(d_disp2), 32'(syn));
    check({tag, "_disp3"}, 32'(d_disp3), u ? 32'h2 : (e ? 32'h1 : 32'h0));
  endtask

  // Launch one decode from IDLE; returns edges from start edge to done, and done one edge later.
  task automatic run_decode(input logic [9:0] cw, output int lat, output logic done_after);
    @(negedge clk);
    cw_in = cw;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(posedge clk);
    #1;
    done_after = done;
  endtask

  // Run ncyc edges after a launch; pulse start at edge pulse_cyc, optionally scramble cw_in.
  task automatic watch(input int ncyc, input int pulse_cyc, input logic scramble,
                       output int ndone, output int first_done);
    ndone = 0;
    first_done = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = (k == pulse_cyc);
      if (scramble) cw_in = 10'($urandom);
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = k;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    logic done_after;
    int ndone;
    int first_done;
    int done_k[2];
    logic [5:0] cap_d[2];
    logic [3:0] cap_s[2];
    logic cap_e[2];

    vecs[0] = '{10'h2FA, 6'b101110, 4'd0,  1'b0, 1'b0};  // clean
    vecs[1] = '{10'h2DA, 6'b101110, 4'd6,  1'b1, 1'b0};  // position 6 flipped
    vecs[2] = '{10'h0EA, 6'b001100, 4'd15, 1'b0, 1'b1};  // positions 5 and 10 flipped
    vecs[3] = '{10'h0F2, 6'b001110, 4'd14, 1'b0, 1'b1};  // positions 4 and 10 flipped
    vecs[4] = '{10'h2FB, 6'b101110, 4'd1,  1'b1, 1'b0};  // parity position 1 flipped
    vecs[5] = '{10'h0FA, 6'b101110, 4'd10, 1'b1, 1'b0};  // last position flipped
    vecs[6] = '{10'h2FE, 6'b101110, 4'd3,  1'b1, 1'b0};  // first data position flipped
    vecs[7] = '{10'h000, 6'b000000, 4'd0,  1'b0, 1'b0};
    vecs[8] = '{10'h3FF, 6'b111111, 4'd11, 1'b0, 1'b1};  // syndrome 11, raw data kept

    rst   = 1'b0;
    start = 1'b0;
    cw_in = '0;
    #12;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check_result("rst", 6'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_decode(vecs[i].cw, lat, done_after);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd11);
      check_result($sformatf("v%0d", i), vecs[i].d, vecs[i].syn, vecs[i].err, vecs[i].uerr);
      check($sformatf("v%0d_done_drop", i), 32'(done_after), 32'h0);
    end

    // start pulsed at E5 while busy: one done, at E11
    @(negedge clk);
    cw_in = 10'h2FA;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("launch_busy", 32'(busy), 32'h1);
    watch(30, 5, 1'b0, ndone, first_done);
    check("busy_start_ndone", 32'(ndone), 32'd1);
    check("busy_start_when", 32'(first_done), 32'd11);
    check_result("busy_start", 6'b101110, 4'd0, 1'b0, 1'b0);

    // cw_in scrambled during the scan must not matter
    @(negedge clk);
    cw_in = 10'h2DA;
    start = 1'b1;
    @(posedge clk);
    watch(14, 0, 1'b1, ndone, first_done);
    check("scramble_ndone", 32'(ndone), 32'd1);
    check_result("scramble", 6'b101110, 4'd6, 1'b1, 1'b0);

    // reset at E6 of a decode: outputs clear at once, no done afterwards
    @(negedge clk);
    cw_in = 10'h0EA;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check_result("abort", 6'd0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    watch(15, 0, 1'b0, ndone, first_done);
    check("abort_ndone", 32'(ndone), 32'd0);
    run_decode(10'h2FA, lat, done_after);
    check("post_abort_latency", 32'(lat), 32'd11);
    check_result("post_abort", 6'b101110, 4'd0, 1'b0, 1'b0);

    // start held across two decodes: done pulses 13 edges apart
    @(negedge clk);
    cw_in = 10'h2FA;
    start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) cw_in = 10'h2DA;
      if (k == 14) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        if (ndone < 2) begin
          done_k[ndone] = k;
          cap_d[ndone]  = d_out;
          cap_s[ndone]  = syndrome;
          cap_e[ndone]  = err;
        end
        ndone++;
      end
    end
    check("b2b_ndone", 32'(ndone), 32'd2);
    if (ndone >= 2) begin
      check("b2b_first", 32'(done_k[0]), 32'd11);
      check("b2b_gap", 32'(done_k[1] - done_k[0]), 32'd13);
      check("b2b_d0", 32'(cap_d[0]), 32'(6'b101110));
      check("b2b_s0", 32'(cap_s[0]), 32'd0);
      check("b2b_e0", 32'(cap_e[0]), 32'h0);
      check("b2b_d1", 32'(cap_d[1]), 32'(6'b101110));
      check("b2b_s1", 32'(cap_s[1]), 32'd6);
      check("b2b_e1", 32'(cap_e[1]), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
